alu_seq_exec: RTL
=================

// Module: alu_seq_exec
// PURPOSE
//  Sequential 32-bit ALU executing the 6-bit function codes produced by the ALU-control decoder.
//  Sits in the execute stage; takes operands plus code under a valid/ready handshake, returns result + flags.
//  Logic/arith ops finish in 1 cycle; variable shifts (SLLV/SRLV/SRAV) run bit-serially, 1 bit/cycle.
// PARAMETERS
//  DATA_W   32  operand/result width
//  SHAMT_W  5   shift-amount width, taken from i_a[SHAMT_W-1:0]
// PORTS
//  i_clk         in   1       clock, all state on rising edge
//  i_rst_n       in   1       asynchronous, active-low reset
//  i_valid       in   1       request valid
//  o_ready       out  1       unit can accept a request (state IDLE)
//  i_aluControl  in   6       function code (MIPS funct encoding)
//  i_a           in   DATA_W  operand A (rs); shift amount for *V shifts
//  i_b           in   DATA_W  operand B (rt/imm); value shifted; LUI source
//  o_valid       out  1       result valid, held until taken
//  i_ready       in   1       consumer accepts result
//  o_result      out  DATA_W  result
//  o_zero        out  1       o_result == 0
//  o_overflow    out  1       signed overflow (ADD/SUB only)
//  o_illegal     out  1       code not in supported set
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, o_valid=0, o_result=0, o_zero=0, o_overflow=0, o_illegal=0;
//   o_ready=1 after reset. In-flight op abandoned, no result emitted.
//  Accept: i_valid & o_ready at rising edge; code and operands registered; o_ready drops next cycle.
//  FSM: IDLE -accept, non-shift or shamt==0-> DONE; IDLE -accept, shift, shamt>0-> SHIFT;
//   SHIFT: shift 1 bit/cycle, decrement count; count reaches 0 -> DONE;
//   DONE: o_valid=1; o_valid & i_ready -> IDLE. No accept while SHIFT/DONE (max 1 op per 2 cycles).
//  Latency accept->o_valid: 1 cycle for non-shifts and shamt 0; 1+shamt for shifts (max 32).
//  Ops (result to o_result):
//   0x20 ADD / 0x21 ADDU: a+b mod 2^32;  0x22 SUB / 0x23 SUBU: a-b mod 2^32
//   0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR: bitwise
//   0x2A SLT: {31'b0, $signed(a)<$signed(b)};  0x2B SLTU: unsigned compare
//   0x04 SLLV: b<<a[4:0];  0x06 SRLV: b>>a[4:0] zero-fill;  0x07 SRAV: arith, sign b[31] fill
//   0x3C LUI: {b[15:0],16'h0}
//   other: result 0, o_illegal=1, latency 1, o_zero=1.
//  o_overflow: ADD -> a[31]==b[31] && r[31]!=a[31]; SUB -> a[31]!=b[31] && r[31]!=a[31]; else 0.
//   Result still written wrapped; trapping is upstream's job.
//  Outputs o_result/flags registered, stable while o_valid high and i_ready low (backpressure).
//  Flags updated only when entering DONE; hold last values in IDLE.
//  Shift amount uses a[4:0] only; a[31:5] ignored. Operands not re-sampled during SHIFT.
//  i_valid ignored (not errors) while o_ready=0; requester must hold until accepted.
// TESTING
//  Reset mid-SRAV (shamt 20, cycle 5) -> o_valid=0, o_ready=1 next cycle, all outputs 0.
//  ADD a=7FFFFFFF b=1 -> r=80000000, overflow=1; ADDU same -> overflow=0, latency 1.
//  SUB a=5 b=5 -> r=0, zero=1; SLT a=FFFFFFFF b=1 -> 1; SLTU same -> 0.
//  SRAV a=4 b=80000000 -> r=F8000000 after 5 cycles; SLLV a=0 b=1234 -> 1234, latency 1.
//  Backpressure: i_ready=0 for 3 cycles in DONE -> o_valid/o_result held, o_ready=0, new i_valid ignored.
//  Code 0x3F -> r=0, illegal=1; then LUI b=0000ABCD -> r=ABCD0000, illegal=0.

Source files
------------

// File: rtl/alu_seq_exec_if.sv
// ---------------------------------------------------------------------------
// alu_seq_exec_if
//   Groups the request and result handshake signals of the sequential ALU.
//   Clock and reset are not part of the bundle and stay plain module ports.
//
//   Request side (requester -> ALU):
//     i_valid       request valid, held by the requester until accepted
//     i_aluControl  6-bit function code (MIPS funct encoding)
//     i_a           operand A; its low SHAMT_W bits are the shift amount
//     i_b           operand B; the value shifted and the LUI source
//   Request side (ALU -> requester):
//     o_ready       ALU can take a new request
//   Result side (ALU -> consumer):
//     o_valid       result valid, held until taken
//     o_result      result word
//     o_zero        o_result == 0
//     o_overflow    signed overflow for ADD/SUB
//     o_illegal     function code not supported
//   Result side (consumer -> ALU):
//     i_ready       consumer takes the result
//
//   Modports:
//     slave   - the ALU itself
//     master  - the requester/consumer (execute-stage control or a bench)
// ---------------------------------------------------------------------------
interface alu_seq_exec_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
);

  logic              i_valid;
  logic              o_ready;
  logic [5:0]        i_aluControl;
  logic [DATA_W-1:0] i_a;
  logic [DATA_W-1:0] i_b;
  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_result;
  logic              o_zero;
  logic              o_overflow;
  logic              o_illegal;

  modport slave (
    input  i_valid,
    input  i_aluControl,
    input  i_a,
    input  i_b,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_result,
    output o_zero,
    output o_overflow,
    output o_illegal
  );

  modport master (
    output i_valid,
    output i_aluControl,
    output i_a,
    output i_b,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_result,
    input  o_zero,
    input  o_overflow,
    input  o_illegal
  );

endinterface

// File: rtl/alu_seq_exec.sv
// ---------------------------------------------------------------------------
// alu_seq_exec
//   Sequential 32-bit execute-stage ALU. A request (function code plus two
//   operands) is taken with a valid/ready handshake; the result and its flags
//   are returned with a second valid/ready handshake.
//
//   Logic and arithmetic operations finish in a single cycle. The variable
//   shifts SLLV/SRLV/SRAV are done bit-serially, one bit position per cycle,
//   so a shift by n takes 1+n cycles from accept to o_valid.
//
//   Ports:
//     i_clk    clock, all state changes on the rising edge
//     i_rst_n  asynchronous active-low reset
//     bus      alu_seq_exec_if.slave bundle (request, result and flags)
// ---------------------------------------------------------------------------
module alu_seq_exec #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  alu_seq_exec_if.slave bus
);

  // Supported function codes
  localparam logic [5:0] OP_SLLV = 6'h04;
  localparam logic [5:0] OP_SRLV = 6'h06;
  localparam logic [5:0] OP_SRAV = 6'h07;
  localparam logic [5:0] OP_ADD  = 6'h20;
  localparam logic [5:0] OP_ADDU = 6'h21;
  localparam logic [5:0] OP_SUB  = 6'h22;
  localparam logic [5:0] OP_SUBU = 6'h23;
  localparam logic [5:0] OP_AND  = 6'h24;
  localparam logic [5:0] OP_OR   = 6'h25;
  localparam logic [5:0] OP_XOR  = 6'h26;
  localparam logic [5:0] OP_NOR  = 6'h27;
  localparam logic [5:0] OP_SLT  = 6'h2A;
  localparam logic [5:0] OP_SLTU = 6'h2B;
  localparam logic [5:0] OP_LUI  = 6'h3C;

  localparam int HALF_W = DATA_W / 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state_q,    state_d;
  logic [5:0]          op_q,       op_d;
  logic [DATA_W-1:0]   shiftReg_q, shiftReg_d;
  logic [SHAMT_W-1:0]  count_q,    count_d;
  logic [DATA_W-1:0]   result_q,   result_d;
  logic                zero_q,     zero_d;
  logic                overflow_q, overflow_d;
  logic                illegal_q,  illegal_d;

  logic [DATA_W-1:0]   aluResult;
  logic                aluOverflow;
  logic                aluIllegal;
  logic                isShift;
  logic [SHAMT_W-1:0]  shamt;
  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   diff;
  logic [DATA_W-1:0]   shiftStep;

  // Single-cycle datapath working directly on the request operands. It only
  // matters in IDLE, when a request may be accepted. For the variable shifts
  // it yields operand B unchanged, which is the correct result for shamt 0;
  // non-zero amounts are handed to the bit-serial shifter instead.
  always_comb begin
    aluResult   = '0;
    aluOverflow = 1'b0;
    aluIllegal  = 1'b0;
    isShift     = 1'b0;
    shamt       = bus.i_a[SHAMT_W-1:0];
    sum         = bus.i_a + bus.i_b;
    diff        = bus.i_a - bus.i_b;
    case (bus.i_aluControl)
      OP_ADD: begin
        aluResult   = sum;
        aluOverflow = (bus.i_a[DATA_W-1] == bus.i_b[DATA_W-1]) &&
                      (sum[DATA_W-1] != bus.i_a[DATA_W-1]);
      end
      OP_ADDU: aluResult = sum;
      OP_SUB: begin
        aluResult   = diff;
        aluOverflow = (bus.i_a[DATA_W-1] != bus.i_b[DATA_W-1]) &&
                      (diff[DATA_W-1] != bus.i_a[DATA_W-1]);
      end
      OP_SUBU: aluResult = diff;
      OP_AND:  aluResult = bus.i_a & bus.i_b;
      OP_OR:   aluResult = bus.i_a | bus.i_b;
      OP_XOR:  aluResult = bus.i_a ^ bus.i_b;
      OP_NOR:  aluResult = ~(bus.i_a | bus.i_b);
      OP_SLT:  aluResult = {{(DATA_W-1){1'b0}}, ($signed(bus.i_a) < $signed(bus.i_b))};
      OP_SLTU: aluResult = {{(DATA_W-1){1'b0}}, (bus.i_a < bus.i_b)};
      OP_LUI:  aluResult = {bus.i_b[HALF_W-1:0], {HALF_W{1'b0}}};
      OP_SLLV, OP_SRLV, OP_SRAV: begin
        isShift   = 1'b1;
        aluResult = bus.i_b;
      end
      default: aluIllegal = 1'b1;
    endcase
  end

  // One bit position of the serial shifter, direction and fill chosen by the
  // latched function code so the request operands need not stay stable.
  always_comb begin
    shiftStep = shiftReg_q;
    case (op_q)
      OP_SLLV: shiftStep = shiftReg_q << 1;
      OP_SRLV: shiftStep = shiftReg_q >> 1;
      OP_SRAV: shiftStep = $signed(shiftReg_q) >>> 1;
      default: shiftStep = shiftReg_q;
    endcase
  end

  // Next-state logic for the IDLE -> (SHIFT) -> DONE -> IDLE sequence.
  // Result and flags are only written on the transition into DONE, so they
  // stay put through backpressure and while the unit sits idle afterwards.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    shiftReg_d = shiftReg_q;
    count_d    = count_q;
    result_d   = result_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    illegal_d  = illegal_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          op_d = bus.i_aluControl;
          if (isShift && (shamt != '0)) begin
            shiftReg_d = bus.i_b;
            count_d    = shamt;
            state_d    = SHIFT;
          end else begin
            result_d   = aluResult;
            zero_d     = (aluResult == '0);
            overflow_d = aluOverflow;
            illegal_d  = aluIllegal;
            state_d    = DONE;
          end
        end
      end
      SHIFT: begin
        shiftReg_d = shiftStep;
        count_d    = count_q - 1'b1;
        // The last bit is being shifted this cycle, so the stepped value is
        // the final result and can go straight to the output register.
        if (count_q == SHAMT_W'(1)) begin
          result_d   = shiftStep;
          zero_d     = (shiftStep == '0);
          overflow_d = 1'b0;
          illegal_d  = 1'b0;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset abandons any in-flight operation
  // and clears the visible result and flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      shiftReg_q <= '0;
      count_q    <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      shiftReg_q <= shiftReg_d;
      count_q    <= count_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.o_ready    = (state_q == IDLE);
  assign bus.o_valid    = (state_q == DONE);
  assign bus.o_result   = result_q;
  assign bus.o_zero     = zero_q;
  assign bus.o_overflow = overflow_q;
  assign bus.o_illegal  = illegal_q;

endmodule
